// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to the combinational shift->ALU datapath,
// chains passes by feeding Result back into A, and returns the final result.
module alu_cmd_sequencer #(
    parameter int WIDTH = 5,
    parameter int SHW   = 2,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_bshift,
    input  logic             cmd_dir,
    input  logic [2:0]       cmd_ctrl,
    input  logic [CNTW-1:0]  cmd_iter,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [SHW-1:0]   dp_bshift,
    output logic             dp_dir,
    output logic [2:0]       dp_ctrl,
    input  logic [WIDTH-1:0] dp_result,
    input  logic [3:0]       dp_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_dp_a;
    logic [WIDTH-1:0] r_dp_b;
    logic [SHW-1:0]   r_dp_bshift;
    logic             r_dp_dir;
    logic [2:0]       r_dp_ctrl;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;

    // Datapath operands are driven only from registers, never from cmd_*.
    assign dp_a       = r_dp_a;
    assign dp_b       = r_dp_b;
    assign dp_bshift  = r_dp_bshift;
    assign dp_dir     = r_dp_dir;
    assign dp_ctrl    = r_dp_ctrl;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and handshake outputs; cmd_ready is masked while reset is high.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = !reset;
                w_accept  = cmd_valid && !reset;
                if (w_accept) w_next = ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand latch, pass chaining and final result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_dp_bshift  <= '0;
            r_dp_dir     <= 1'b0;
            r_dp_ctrl    <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dp_a      <= cmd_a;
                        r_dp_b      <= cmd_b;
                        r_dp_bshift <= cmd_bshift;
                        r_dp_dir    <= cmd_dir;
                        r_dp_ctrl   <= cmd_ctrl;
                        r_cnt       <= cmd_iter;
                    end
                end
                ISSUE: begin
                    if (r_cnt != '0) begin
                        r_dp_a <= dp_result;
                        r_cnt  <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_result <= dp_result;
                        r_rsp_flags  <= dp_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
